// File: rtl/triangle_pkg.sv
// Shared types, widths and the triangular-number helper for the triangle blocks.
package triangle_pkg;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} tri_state_e;

    localparam int unsigned TRI_DATA_W = 32;
    localparam int unsigned TRI_IDX_W  = 17;
    localparam int unsigned TRI_T_W    = 34;

    // T(idx) = idx*(idx+1)/2, product formed one bit wider than the result
    function automatic logic [TRI_T_W-1:0] tri_num(input logic [TRI_IDX_W-1:0] idx);
        logic [TRI_T_W:0] p;
        p = (TRI_T_W+1)'(idx) * ((TRI_T_W+1)'(idx) + (TRI_T_W+1)'(1));
        return TRI_T_W'(p >> 1);
    endfunction

endpackage

// File: rtl/triangle_root_if.sv
// go/done level-handshake bus shared by the triangle and triangle_root blocks.
interface triangle_root_if #(parameter int unsigned DATA_W = 32);

    logic [DATA_W-1:0] in0;
    logic              go;
    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;
    logic              done;

    modport master (output in0, go, input out0, out1, done);
    modport slave  (input in0, go, output out0, out1, done);

endinterface

// File: rtl/tri_step.sv
// One binary-search step: try setting bit_idx in n and keep it if T(cand) <= x.
module tri_step #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = DATA_W / 2 + 1,
    parameter int unsigned BIT_W  = $clog2(IDX_W)
) (
    input  logic [DATA_W-1:0] x,
    input  logic [IDX_W-1:0]  n,
    input  logic [BIT_W-1:0]  bit_idx,
    output logic [IDX_W-1:0]  n_next_c,
    output logic              accept_c,
    output logic [DATA_W-1:0] rem_next_c
);

    localparam int unsigned PROD_W = 2 * IDX_W + 1;
    localparam int unsigned T_W    = 2 * IDX_W;

    logic [IDX_W-1:0] cand;
    logic [PROD_W-1:0] prod;
    logic [T_W-1:0]    tri_val;

    // rem_next_c is only meaningful when accept_c is set
    always_comb begin
        cand       = n | (IDX_W'(1) << bit_idx);
        prod       = PROD_W'(cand) * (PROD_W'(cand) + PROD_W'(1));
        tri_val    = T_W'(prod >> 1);
        accept_c   = tri_val <= T_W'(x);
        n_next_c   = accept_c ? cand : n;
        rem_next_c = x - DATA_W'(tri_val);
    end

endmodule

// File: rtl/triangle_root.sv
// Triangular root: largest n with n(n+1)/2 <= X and the remainder, fixed 17-cycle search.
module triangle_root
    import triangle_pkg::*;
#(
    parameter int unsigned DATA_W = TRI_DATA_W
) (
    input  logic            clk,
    input  logic            reset,
    triangle_root_if.slave  bus
);

    localparam int unsigned IDX_W = DATA_W / 2 + 1;
    localparam int unsigned BIT_W = $clog2(IDX_W);

    tri_state_e        state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] out0_q, out0_d;
    logic [DATA_W-1:0] out1_q, out1_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  step_n;
    logic              step_acc;
    logic [DATA_W-1:0] step_rem;

    tri_step #(.DATA_W(DATA_W), .IDX_W(IDX_W), .BIT_W(BIT_W)) u_step (
        .x          (x_q),
        .n          (n_q),
        .bit_idx    (bit_q),
        .n_next_c   (step_n),
        .accept_c   (step_acc),
        .rem_next_c (step_rem)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d = SEARCH;
                    x_d     = bus.in0;
                    n_d     = '0;
                    rem_d   = bus.in0;
                    bit_d   = BIT_W'(IDX_W - 1);
                end
            end
            SEARCH: begin
                n_d = step_n;
                if (step_acc) rem_d = step_rem;
                // last bit: publish the result in the same edge
                if (bit_q == '0) begin
                    out0_d  = DATA_W'(step_n);
                    out1_d  = step_acc ? step_rem : rem_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    bit_d = bit_q - BIT_W'(1);
                end
            end
            DONE: begin
                if (!bus.go) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            n_q     <= '0;
            rem_q   <= '0;
            bit_q   <= BIT_W'(IDX_W - 1);
            out0_q  <= '0;
            out1_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            done_q  <= done_d;
        end
    end

    assign bus.out0 = out0_q;
    assign bus.out1 = out1_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_triangle_root.sv
// Bench for triangle_root: cycle-level reference model, directed corner runs and random runs.
module tb_triangle_root;
    import triangle_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   armed = 1'b0;

    triangle_root_if #(.DATA_W(32)) bus ();

    triangle_root #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // n from integer sqrt: T(n) <= x  <=>  (2n+1)^2 <= 8x+1
    function automatic longint ref_n(input logic [31:0] x);
        longint v, r, y;
        v = 8 * longint'(x) + 1;
        r = v;
        y = (r + 1) / 2;
        while (y < r) begin
            r = y;
            y = (r + v / r) / 2;
        end
        return (r - 1) / 2;
    endfunction

    function automatic longint ref_rem(input logic [31:0] x);
        longint n;
        n = ref_n(x);
        return longint'(x) - n * (n + 1) / 2;
    endfunction

    // Reference: 17 edges after a start, result appears; done clears after go is seen low
    logic        m_done = 1'b0;
    logic [31:0] m_o0 = '0, m_o1 = '0, m_x = '0;
    int          m_cnt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_done <= 1'b0;
            m_o0   <= '0;
            m_o1   <= '0;
            m_x    <= '0;
            m_cnt  <= 0;
        end else if (m_done) begin
            if (!bus.go) m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_o0   <= 32'(ref_n(m_x));
                m_o1   <= 32'(ref_rem(m_x));
                m_done <= 1'b1;
            end
        end else if (bus.go) begin
            m_x   <= bus.in0;
            m_cnt <= 17;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_done", longint'(bus.done), longint'(m_done));
            chk("cyc_out0", longint'(bus.out0), longint'(m_o0));
            chk("cyc_out1", longint'(bus.out1), longint'(m_o1));
        end
    end

    // Called at posedge+1; returns at posedge+1 with go dropped and done seen low
    task automatic run(input logic [31:0] x, input int hold, input bit poke,
                       output logic [31:0] r0, output logic [31:0] r1);
        int cyc;
        bit seen;
        bus.go  = 1'b1;
        bus.in0 = x;
        @(posedge clk); #1;
        if (poke) bus.in0 = 32'd7;
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("latency", longint'(cyc), 17);
        r0 = bus.out0;
        r1 = bus.out1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            chk("hold_done", longint'(bus.done), 1);
            chk("hold_out0", longint'(bus.out0), longint'(r0));
        end
        bus.go = 1'b0;
        @(posedge clk); #1;
        chk("done_fall", longint'(bus.done), 0);
    endtask

    initial begin
        logic [31:0] r0, r1, x;
        int k, mode;
        bus.go  = 1'b0;
        bus.in0 = '0;
        #1 reset = 1'b0;
        #1 armed = 1'b1;
        #13;
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_out0", longint'(bus.out0), 0);
        chk("rst_out1", longint'(bus.out1), 0);
        #6 reset = 1'b1;
        @(posedge clk); #1;

        chk("model_ffff", ref_n(32'hFFFF_FFFF), 92681);
        chk("model_4949", ref_rem(32'd4949), 98);

        run(32'd5, 0, 1'b0, r0, r1);
        chk("x5_n", longint'(r0), 2);   chk("x5_r", longint'(r1), 2);
        run(32'd0, 0, 1'b0, r0, r1);
        chk("x0_n", longint'(r0), 0);   chk("x0_r", longint'(r1), 0);
        run(32'd6, 0, 1'b0, r0, r1);
        chk("x6_n", longint'(r0), 3);   chk("x6_r", longint'(r1), 0);
        run(32'd4950, 0, 1'b0, r0, r1);
        chk("x4950_n", longint'(r0), 99); chk("x4950_r", longint'(r1), 0);
        run(32'd4949, 0, 1'b1, r0, r1);
        chk("x4949_n", longint'(r0), 98); chk("x4949_r", longint'(r1), 98);
        run(32'hFFFF_FFFF, 0, 1'b0, r0, r1);
        chk("xmax_n", longint'(r0), 92681); chk("xmax_r", longint'(r1), 37074);
        run(32'd6, 40, 1'b0, r0, r1);
        chk("hold_n", longint'(r0), 3); chk("hold_r", longint'(r1), 0);

        // Back-to-back: previous 2/2 must persist until the second run's last edge
        run(32'd5, 0, 1'b0, r0, r1);
        run(32'd15, 0, 1'b0, r0, r1);
        chk("x15_n", longint'(r0), 5);  chk("x15_r", longint'(r1), 0);

        // Reset partway through SEARCH, with a nonzero prior result on the outputs
        bus.go  = 1'b1;
        bus.in0 = 32'd1000;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_out0", longint'(bus.out0), 5);
        reset  = 1'b0;
        bus.go = 1'b0;
        #1;
        chk("midrst_done", longint'(bus.done), 0);
        chk("midrst_out0", longint'(bus.out0), 0);
        chk("midrst_out1", longint'(bus.out1), 0);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 20; i++) @(posedge clk);
        #1;
        chk("no_resume", longint'(bus.done), 0);
        run(32'd10, 0, 1'b0, r0, r1);
        chk("x10_n", longint'(r0), 4);  chk("x10_r", longint'(r1), 0);

        // Random values, weighted towards exact triangular numbers and their neighbours
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            k    = int'($urandom_range(1, 92680));
            case (mode)
                0:       x = $urandom;
                1:       x = 32'(tri_num(17'(k)));
                default: x = 32'(tri_num(17'(k))) - 32'd1;
            endcase
            run(x, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r0, r1);
            chk("rand_n", longint'(r0), ref_n(x));
            chk("rand_r", longint'(r1), ref_rem(x));
        end

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
